// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multi-cycle HI/LO multiply/divide unit for the MIPS datapath. It owns the
//   architectural HI and LO registers. MULT/MULTU/DIV/DIVU run one radix-2
//   step per cycle for WIDTH cycles, then one cycle to fix up signs and write
//   back. MTHI/MTLO write HI/LO directly from IDLE.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   start  : one-cycle issue strobe (only looked at in IDLE)
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   a, b   : rs / rt operands, sampled on the start edge only
//   flush  : cancels an in-flight mult/div without touching HI/LO
//   busy   : high while CALC or FIX
//   done   : registered one-cycle pulse when a mult/div writes HI/LO
//   hi, lo : architectural HI and LO registers
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO are written from here
// CALC  | one shift-add / restoring shift-subtract step per cycle
// FIX   | apply result signs, write HI/LO, pulse done
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r, div_zero;

  logic               issue_md, issue_mt, write_res;
  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;

  logic [WIDTH-1:0]   rem_cur;
  logic [WIDTH:0]     trial, diff;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // ---------------- control ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // flush wins over both a simultaneous start in IDLE and the FIX write-back.
  always_comb begin
    state_next = state;
    issue_md   = 1'b0;
    issue_mt   = 1'b0;
    write_res  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          if (op <= OP_DIVU) begin
            issue_md   = 1'b1;
            state_next = CALC;
          end else if (op == OP_MTHI || op == OP_MTLO) begin
            issue_mt = 1'b1;
          end
        end
      end
      CALC: begin
        if (flush)                state_next = IDLE;
        else if (cnt == '0)       state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        write_res  = !flush;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC) || (state == FIX);

  // ---------------- operand capture ----------------
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    // most-negative maps onto itself, which is its correct unsigned magnitude
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;
  end

  // ---------------- one iteration ----------------
  // Both algorithms walk the operand MSB-first using the down-counter as the
  // bit index. Divide keeps the partial remainder in acc[2W-1:W] and shifts
  // quotient bits into acc[W-1:0].
  always_comb begin
    rem_cur = acc[2*WIDTH-1:WIDTH];
    trial   = {rem_cur, mag_a[cnt]};
    diff    = trial - {1'b0, mag_b};
    if (is_div) begin
      if (diff[WIDTH]) acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_step = {diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = (acc << 1) + {{WIDTH{1'b0}}, ({WIDTH{mag_b[cnt]}} & mag_a)};
    end
  end

  // ---------------- sign fix-up ----------------
  // Overflow (most-negative / -1) needs no special case: magnitude quotient
  // 2^(W-1) negated wraps back to most-negative, remainder is 0.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_zero) begin
      res_lo = '1;
      res_hi = neg_r ? -mag_a : mag_a;   // reconstructs the original dividend
    end else if (is_div) begin
      res_lo = quo;
      res_hi = rem;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= write_res;
      if (issue_md) begin
        mag_a    <= abs_a;
        mag_b    <= abs_b;
        is_div   <= op[1];
        neg_q    <= a_neg ^ b_neg;
        neg_r    <= a_neg;
        div_zero <= op[1] && (b == '0);
        acc      <= '0;
        cnt      <= CW'(WIDTH-1);
      end else if (state == CALC && !flush) begin
        acc <= acc_step;
        cnt <= cnt - CW'(1);
      end
      if (issue_mt) begin
        if (op == OP_MTHI) hi <= a;
        else               lo <= a;
      end
      if (write_res) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8, flush32, flush8;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op), .a(a), .b(b),
    .flush(flush32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .flush(flush8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one mult/div, scramble a/b after the start edge, wait (bounded) for
  // done and check latency, busy length and the result. poke_at >= 0 fires an
  // MTHI start while the unit is busy, which must be ignored.
  task automatic run_md(input string tag, input bit w8, input logic [2:0] o,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int poke_at);
    int cyc, bcnt, lat;
    logic dn, bz;
    lat = w8 ? 9 : 33;
    @(negedge clk);
    op = o; a = av; b = bv;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    a = 32'h3C3C_C3C3; b = 32'h0F0F_F0F0;
    cyc = 0; bcnt = 0; dn = 1'b0;
    for (int i = 0; i < 60 && !dn; i++) begin
      bz = w8 ? busy8 : busy32;
      if (bz) bcnt++;
      if (i == poke_at) begin
        op = 3'd4; a = 32'hDEAD_BEEF;
        if (w8) start8 = 1'b1; else start32 = 1'b1;
      end
      @(posedge clk); #1;
      start8 = 1'b0; start32 = 1'b0;
      cyc++;
      dn = w8 ? done8 : done32;
    end
    check({tag, " latency"}, 64'(cyc), 64'(lat));
    check({tag, " busy_cycles"}, 64'(bcnt), 64'(lat));
    check({tag, " hi"}, 64'(w8 ? {24'b0, hi8} : hi32), 64'(eh));
    check({tag, " lo"}, 64'(w8 ? {24'b0, lo8} : lo32), 64'(el));
    check({tag, " busy_at_done"}, 64'(w8 ? busy8 : busy32), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_hi, old_lo;
    int seen;

    reset = 1'b1; start32 = 1'b0; start8 = 1'b0; flush32 = 1'b0; flush8 = 1'b0;
    op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi32/lo32", {hi32, lo32}, 64'd0);
    check("reset busy/done32", {62'd0, busy32, done32}, 64'd0);
    check("reset w8 outputs", {46'd0, hi8, lo8, busy8, done8}, 64'd0);
    @(negedge clk); reset = 1'b0;

    // main function, issued back-to-back in the done cycle
    run_md("mult", 0, 3'd0, 32'hFEDC_1234, 32'hFFFF_ABCD, 32'h0000_0060, 32'h042F_4FA4, -1);
    @(posedge clk); #1;
    check("mult done_one_cycle", 64'(done32), 64'd0);
    run_md("multu", 0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1);
    run_md("div_neg7_2", 0, 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_md("divu_big", 0, 3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, -1);
    run_md("divu_by0", 0, 3'd3, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, -1);
    run_md("div_ovf", 0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);
    run_md("div_neg_by0", 0, 3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1);
    run_md("div_100_m7", 0, 3'd2, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, -1);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk); op = 3'd4; a = 32'hA5A5_A5A5; start32 = 1'b1;
    @(posedge clk); #1;
    check("mthi hi", 64'(hi32), 64'h0A5A5_A5A5);
    check("mthi busy/done", {62'd0, busy32, done32}, 64'd0);
    op = 3'd5; a = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("mtlo lo", 64'(lo32), 64'h5A5A_5A5A);
    check("mtlo hi_kept", 64'(hi32), 64'hA5A5_A5A5);
    check("mtlo busy/done", {62'd0, busy32, done32}, 64'd0);
    @(posedge clk); #1;
    check("mt done_never", 64'(done32), 64'd0);

    // start while busy is ignored
    run_md("start_busy", 0, 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // flush at iteration 10
    old_hi = hi32; old_lo = lo32;
    @(negedge clk); op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush32 = 1'b1;
    @(posedge clk); #1; flush32 = 1'b0;
    check("flush busy_next", 64'(busy32), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) seen++;
    end
    check("flush no_done", 64'(seen), 64'd0);
    check("flush hi/lo kept", {hi32, lo32}, {old_hi, old_lo});

    // flush beats a simultaneous start in IDLE
    @(negedge clk); op = 3'd4; a = 32'h0000_1234; start32 = 1'b1; flush32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0; flush32 = 1'b0;
    check("idle_flush mthi", 64'(hi32), 64'(old_hi));
    @(negedge clk); op = 3'd0; a = 32'd3; b = 32'd5; start32 = 1'b1; flush32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0; flush32 = 1'b0;
    check("idle_flush mult busy", 64'(busy32), 64'd0);

    // asynchronous reset mid-CALC
    @(negedge clk); op = 3'd0; a = 32'd3; b = 32'd5; start32 = 1'b1;
    @(posedge clk); #1; start32 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("async_reset hi/lo", {hi32, lo32}, 64'd0);
    check("async_reset busy/done", {62'd0, busy32, done32}, 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("after_reset idle", {62'd0, busy32, done32}, 64'd0);

    // WIDTH=8 instance
    run_md("mult8", 1, 3'd0, 32'h80, 32'h80, 32'h40, 32'h00, -1);
    run_md("div8", 1, 3'd2, 32'h81, 32'h03, 32'hFF, 32'hD6, -1);
    run_md("divu8", 1, 3'd3, 32'hFF, 32'h10, 32'h0F, 32'h0F, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
